pixel_stream_buffer: RTL and testbench

PIXEL_STREAM_BUFFER -- requirements
Module: pixel_stream_buffer

---
 rtl/video_pkg.sv | 23 ++
 rtl/pixel_fifo_mem.sv | 76 +++++++
 rtl/pixel_stream_buffer.sv | 196 +++++++++++++++++++
 tb/tb_pixel_stream_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared types for the pixel stream buffer.
//   rgb_t          : one 24-bit RGB pixel
//   buffer_state_t : buffer control state (SYNC / FILL / RUN)
//   RGB_BLACK      : value driven on rd_data when no pixel is delivered
// ----------------------------------------------------------------------------
package video_pkg;

   typedef logic [23:0] rgb_t;

   // SYNC : waiting for a start-of-frame pixel, FIFO empty
   // FILL : frame start stored, waiting for fill threshold plus display start
   // RUN  : display is consuming pixels from the FIFO
   typedef enum logic [1:0] {
      SYNC = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } buffer_state_t;

   localparam rgb_t RGB_BLACK = 24'h000000;

endpackage

// File: rtl/pixel_fifo_mem.sv
// ----------------------------------------------------------------------------
// pixel_fifo_mem
// Storage for the pixel FIFO: a DEPTH x 24 RAM with synchronous write and a
// registered read port, plus a DEPTH-bit flop array holding the per-entry
// start-of-frame flag so the head flag can be inspected in the same cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en/wr_addr       : write strobe and address
//   wr_rgb/wr_sof       : entry contents
//   rd_en/rd_addr       : read strobe and address (data appears next cycle)
//   rd_clr              : force the read register to black (ignored on rd_en)
//   rd_rgb              : registered read data, holds when idle
//   head_sof            : sof flag of the entry at rd_addr, combinational
// ----------------------------------------------------------------------------
module pixel_fifo_mem
   import video_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  rgb_t          wr_rgb,
   input  logic          wr_sof,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   input  logic          rd_clr,
   output rgb_t          rd_rgb,
   output logic          head_sof
);

   rgb_t             mem_q [DEPTH];
   logic [DEPTH-1:0] sof_q;
   logic [DEPTH-1:0] sof_d;
   rgb_t             rd_rgb_q;
   rgb_t             rd_rgb_d;

   // RAM body carries no reset; stale contents are unreachable because the
   // pointers and level are cleared instead.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_rgb;
      end
   end

   always_comb begin
      sof_d = sof_q;
      if (wr_en) begin
         sof_d[wr_addr] = wr_sof;
      end
   end

   always_comb begin
      rd_rgb_d = rd_rgb_q;
      if (rd_en) begin
         rd_rgb_d = mem_q[rd_addr];
      end else if (rd_clr) begin
         rd_rgb_d = RGB_BLACK;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sof_q    <= '0;
         rd_rgb_q <= RGB_BLACK;
      end else begin
         sof_q    <= sof_d;
         rd_rgb_q <= rd_rgb_d;
      end
   end

   assign rd_rgb   = rd_rgb_q;
   assign head_sof = sof_q[rd_addr];

endmodule

// File: rtl/pixel_stream_buffer.sv
// ----------------------------------------------------------------------------
// pixel_stream_buffer
// Elastic buffer between an upstream pixel source and display video timing.
// Locks onto a start-of-frame pixel, fills to THRESH, then serves one pixel
// per rd_en. Underflow or frame misalignment flushes and resynchronises.
//   pixel_clk, pixel_rst : clock, asynchronous active-high reset
//   in_valid/in_ready    : upstream handshake, in_data + in_sof per pixel
//   rd_en/rd_sof         : display pull, rd_sof marks first active pixel
//   rd_data              : pixel delivered one cycle after rd_en
//   running              : high while serving (RUN)
//   underflow/misalign   : one-cycle error pulses
//   level                : FIFO occupancy, 0..DEPTH
//   state_dbg            : current control state
//
// Handshake: a pixel transfers on any rising clock edge where in_valid and
// in_ready are both high; in_ready depends only on registered state, and the
// source must hold in_data/in_sof stable while in_valid is high and
// in_ready is low.
// ----------------------------------------------------------------------------
module pixel_stream_buffer
   import video_pkg::*;
#(
   parameter int HDISP  = 800,
   parameter int VDISP  = 480,
   parameter int DEPTH  = 256,
   parameter int THRESH = DEPTH / 2
) (
   input  logic                     pixel_clk,
   input  logic                     pixel_rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [23:0]              in_data,
   input  logic                     in_sof,
   input  logic                     rd_en,
   input  logic                     rd_sof,
   output logic [23:0]              rd_data,
   output logic                     running,
   output logic                     underflow,
   output logic                     misalign,
   output logic [$clog2(DEPTH):0]   level,
   output buffer_state_t            state_dbg
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // Elaboration-time parameter sanity.
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 4");
   end
   if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
      $error("THRESH must be in 1..DEPTH");
   end
   if (HDISP < 1 || VDISP < 1) begin : g_bad_frame
      $error("HDISP and VDISP must be positive");
   end

   buffer_state_t state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          underflow_q, underflow_d;
   logic          misalign_q, misalign_d;

   logic accept;
   logic mem_we;
   logic mem_re;
   logic rd_clr;
   logic flush;
   logic head_sof;
   rgb_t mem_rgb;

   always_comb begin
      in_ready    = (state_q == SYNC) || (level_q != LW'(DEPTH));
      accept      = in_valid && in_ready;
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      underflow_d = 1'b0;
      misalign_d  = 1'b0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      rd_clr      = 1'b0;
      flush       = 1'b0;

      unique case (state_q)
         SYNC: begin
            // Only a start-of-frame pixel may open a frame; the rest are dropped.
            rd_clr = rd_en;
            if (accept && in_sof) begin
               mem_we  = 1'b1;
               state_d = FILL;
            end
         end
         FILL: begin
            mem_we = accept;
            if (rd_en) begin
               // Head is the sof pixel written on leaving SYNC.
               if (rd_sof && (level_q >= LW'(THRESH))) begin
                  mem_re  = 1'b1;
                  state_d = RUN;
               end else begin
                  rd_clr = 1'b1;
               end
            end
         end
         RUN: begin
            mem_we = accept;
            if (rd_en) begin
               // No bypass: a same-cycle push cannot rescue an empty FIFO.
               if (level_q == '0) begin
                  underflow_d = 1'b1;
                  flush       = 1'b1;
               end else if (rd_sof != head_sof) begin
                  misalign_d = 1'b1;
                  flush      = 1'b1;
               end else begin
                  mem_re = 1'b1;
               end
            end
         end
         default: begin
            flush = 1'b1;
         end
      endcase

      if (flush) begin
         mem_we  = 1'b0;
         mem_re  = 1'b0;
         rd_clr  = 1'b1;
         state_d = SYNC;
      end

      if (mem_we) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (mem_re) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (mem_we && !mem_re) begin
         level_d = level_q + LW'(1);
      end else if (mem_re && !mem_we) begin
         level_d = level_q - LW'(1);
      end

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         state_q     <= SYNC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         underflow_q <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         underflow_q <= underflow_d;
         misalign_q  <= misalign_d;
      end
   end

   pixel_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk      (pixel_clk),
      .rst      (pixel_rst),
      .wr_en    (mem_we),
      .wr_addr  (wr_ptr_q),
      .wr_rgb   (in_data),
      .wr_sof   (in_sof),
      .rd_en    (mem_re),
      .rd_addr  (rd_ptr_q),
      .rd_clr   (rd_clr),
      .rd_rgb   (mem_rgb),
      .head_sof (head_sof)
   );

   assign rd_data   = mem_rgb;
   assign running   = (state_q == RUN);
   assign underflow = underflow_q;
   assign misalign  = misalign_q;
   assign level     = level_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// ----------------------------------------------------------------------------
// tb_pixel_stream_buffer
// Directed scenarios plus randomized traffic for pixel_stream_buffer with
// DEPTH=16, THRESH=8, compared against a queue-based model of the buffer.
// ----------------------------------------------------------------------------
module tb_pixel_stream_buffer;
   import video_pkg::*;

   localparam int DEPTH  = 16;
   localparam int THRESH = 8;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_data = '0;
   logic        in_sof = 1'b0;
   logic        rd_en = 1'b0;
   logic        rd_sof = 1'b0;
   logic [23:0] rd_data;
   logic        running;
   logic        underflow;
   logic        misalign;
   logic [4:0]  level;
   buffer_state_t state_dbg;

   always #5 clk = ~clk;

   pixel_stream_buffer #(
      .HDISP  (32),
      .VDISP  (4),
      .DEPTH  (DEPTH),
      .THRESH (THRESH)
   ) dut (
      .pixel_clk (clk),
      .pixel_rst (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sof    (in_sof),
      .rd_en     (rd_en),
      .rd_sof    (rd_sof),
      .rd_data   (rd_data),
      .running   (running),
      .underflow (underflow),
      .misalign  (misalign),
      .level     (level),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard / model ----------------
   // exp_q holds {sof, rgb} of every pixel the buffer should currently hold.
   logic [24:0] exp_q[$];
   int          m_mode;      // 0 = waiting for sof, 1 = filling, 2 = serving
   logic [23:0] m_rd;
   bit          m_uf;
   bit          m_ma;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_mode = 0;
      m_rd   = 24'h0;
      m_uf   = 1'b0;
      m_ma   = 1'b0;
   endtask

   // One clock of the reference behaviour, evaluated on the pre-edge model.
   task automatic model_step(input bit v, input logic [23:0] d, input bit s,
                             input bit re, input bit rs);
      bit ready;
      bit acc;
      bit flushed;
      ready   = (m_mode == 0) || (exp_q.size() != DEPTH);
      acc     = v && ready;
      flushed = 1'b0;
      m_uf    = 1'b0;
      m_ma    = 1'b0;
      case (m_mode)
         0: begin
            if (re) m_rd = 24'h0;
            if (acc && s) begin
               exp_q.push_back({1'b1, d});
               m_mode = 1;
            end
         end
         1: begin
            if (re && rs && exp_q.size() >= THRESH) begin
               m_rd   = exp_q.pop_front() & 25'h0FFFFFF;
               m_mode = 2;
            end else if (re) begin
               m_rd = 24'h0;
            end
            if (acc) exp_q.push_back({s, d});
         end
         default: begin
            if (re) begin
               if (exp_q.size() == 0) begin
                  m_uf = 1'b1;
                  flushed = 1'b1;
               end else if (rs != exp_q[0][24]) begin
                  m_ma = 1'b1;
                  flushed = 1'b1;
               end else begin
                  m_rd = exp_q.pop_front() & 25'h0FFFFFF;
               end
            end
            if (flushed) begin
               exp_q.delete();
               m_mode = 0;
               m_rd   = 24'h0;
            end else if (acc) begin
               exp_q.push_back({s, d});
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check_val("rd_data",   rd_data,   m_rd);
      check_val("level",     level,     exp_q.size());
      check_val("running",   running,   m_mode == 2);
      check_val("underflow", underflow, m_uf);
      check_val("misalign",  misalign,  m_ma);
      check_val("in_ready",  in_ready,  (m_mode == 0) || (exp_q.size() != DEPTH));
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge; drives one clock's inputs and checks after it.
   task automatic cycle(input bit v, input logic [23:0] d, input bit s,
                        input bit re, input bit rs);
      in_valid = v;
      in_data  = d;
      in_sof   = s;
      rd_en    = re;
      rd_sof   = rs;
      model_step(v, d, s, re, rs);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic push(input logic [23:0] d, input bit s);
      cycle(1'b1, d, s, 1'b0, 1'b0);
   endtask

   task automatic pull(input bit rs);
      cycle(1'b0, 24'h0, 1'b0, 1'b1, rs);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_data  = '0;
      in_sof   = 1'b0;
      rd_en    = 1'b0;
      rd_sof   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      compare_all();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      #1;
      check_val("reset_rd_data", rd_data, 24'h0);
      check_val("reset_level", level, 0);
      check_val("reset_running", running, 0);
      check_val("reset_underflow", underflow, 0);
      check_val("reset_misalign", misalign, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("reset_in_ready", in_ready, 1);

      // Lock onto frame: three stray pixels, then sof + seven.
      for (int i = 0; i < 3; i++) push(24'h550000 + 24'(i), 1'b0);
      push(24'hAA0001, 1'b1);
      for (int i = 2; i <= 8; i++) push(24'hAA0000 + 24'(i), 1'b0);
      check_val("fill_level", level, 8);
      check_val("fill_state", state_dbg, FILL);
      pull(1'b0);                         // no start condition: no pop
      check_val("fill_no_pop_rd", rd_data, 24'h0);
      check_val("fill_no_pop_level", level, 8);

      // Start and read the frame in order.
      pull(1'b1);
      check_val("start_rd", rd_data, 24'hAA0001);
      check_val("start_running", running, 1);
      for (int i = 2; i <= 8; i++) begin
         pull(1'b0);
         check_val("frame_rd", rd_data, 24'hAA0000 + 24'(i));
      end
      cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1); // rd_sof ignored, rd_data holds
      check_val("hold_rd", rd_data, 24'hAA0008);

      // Underflow.
      pull(1'b0);
      check_val("uf_pulse", underflow, 1);
      check_val("uf_rd", rd_data, 24'h0);
      check_val("uf_running", running, 0);
      check_val("uf_level", level, 0);
      check_val("uf_in_ready", in_ready, 1);
      idle_inputs();
      @(negedge clk);
      check_val("uf_one_cycle", underflow, 0);

      // Fill to full, then push+pull at full in FILL.
      push(24'hBB0000, 1'b1);
      for (int i = 1; i < DEPTH; i++) push(24'hBB0000 + 24'(i), 1'b0);
      check_val("full_level", level, 16);
      check_val("full_in_ready", in_ready, 0);
      cycle(1'b1, 24'hBBFFFF, 1'b0, 1'b1, 1'b0);
      check_val("full_pushpop_level", level, 16);
      pull(1'b1);                         // start: level 15
      cycle(1'b1, 24'hBB0100, 1'b0, 1'b1, 1'b0);
      check_val("run_pushpop_level", level, 15);
      check_val("run_pushpop_rd", rd_data, 24'hBB0001);

      // Misalign: next-frame sof at head, display says not sof.
      do_reset();
      push(24'hCC0000, 1'b1);
      for (int i = 1; i < 8; i++) push(24'hCC0000 + 24'(i), 1'b0);
      push(24'hDD0000, 1'b1);
      for (int i = 0; i < 8; i++) pull(i == 0);
      check_val("ma_pre_running", running, 1);
      pull(1'b0);
      check_val("ma_pulse", misalign, 1);
      check_val("ma_rd", rd_data, 24'h0);
      check_val("ma_state", state_dbg, SYNC);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         bit          v, s, re, rs;
         logic [23:0] d;
         v  = ($urandom_range(0, 9) < 7);
         s  = ($urandom_range(0, 15) == 0);
         d  = 24'($urandom());
         re = ($urandom_range(0, 9) < 5);
         if (exp_q.size() > 0 && $urandom_range(0, 9) != 0) rs = exp_q[0][24];
         else rs = 1'($urandom_range(0, 1));
         cycle(v, d, s, re, rs);
      end

      // Asynchronous reset mid-frame at level 10.
      do_reset();
      push(24'hEE0000, 1'b1);
      for (int i = 1; i < 10; i++) push(24'hEE0000 + 24'(i), 1'b0);
      pull(1'b1);
      push(24'hEE0100, 1'b0);
      check_val("pre_rst_level", level, 10);
      check_val("pre_rst_running", running, 1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_val("arst_level", level, 0);
      check_val("arst_rd", rd_data, 24'h0);
      check_val("arst_running", running, 0);
      check_val("arst_uf", underflow, 0);
      check_val("arst_ma", misalign, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) push(24'h990000 + 24'(i), 1'b0);
      check_val("post_rst_discard", level, 0);
      pull(1'b1);
      check_val("post_rst_no_stale", rd_data, 24'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "timeout");
   end

endmodule
